// File: rtl/contador_vedacao_pkg.sv
// Shared types and default constants for the cork/box counting stage.
package contador_vedacao_pkg;

  // Box-filling state: counting bottles, or full and waiting for removal.
  typedef enum logic {
    NORMAL = 1'b0,
    CHEIA  = 1'b1
  } estado_t;

  localparam int MAX_ROLHAS    = 100;
  localparam int LOTE_ROLHAS   = 15;
  localparam int DUZIA         = 12;
  localparam int LIMIAR_ALARME = 5;
  localparam int W_ROLHAS      = 7;

endpackage

// File: rtl/contador_vedacao_detector_borda.sv
// Rising-edge detector: one pulse per high level of the input, in the same
// cycle as the rise.
module detector_borda (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic borda
);

  logic atraso_q;
  logic atraso_d;

  // Next value of the delayed copy is simply the current input.
  always_comb begin
    atraso_d = d;
  end

  // Delay register, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      atraso_q <= 1'b0;
    end else begin
      atraso_q <= atraso_d;
    end
  end

  assign borda = d & ~atraso_q;

endmodule

// File: rtl/contador_vedacao.sv
// Cork magazine stock and bottles-per-box counter downstream of the sealing
// controller; grants RO (permission to seal) from registered state only.
module contador_vedacao
  import contador_vedacao_pkg::*;
#(
  parameter int MAX_ROLHAS    = contador_vedacao_pkg::MAX_ROLHAS,
  parameter int LOTE_ROLHAS   = contador_vedacao_pkg::LOTE_ROLHAS,
  parameter int DUZIA         = contador_vedacao_pkg::DUZIA,
  parameter int LIMIAR_ALARME = contador_vedacao_pkg::LIMIAR_ALARME,
  parameter int W_ROLHAS      = contador_vedacao_pkg::W_ROLHAS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                GP,
  input  logic                ADD,
  input  logic                RETIRA,
  output logic                RO,
  output logic [W_ROLHAS-1:0] ROLHAS,
  output logic [3:0]          GARRAFAS,
  output logic                CAIXA_CHEIA,
  output logic                ALARME,
  output logic                ERRO
);

  // Stock arithmetic runs one bit wider so reload never wraps before the clamp.
  localparam logic [W_ROLHAS:0]   LOTE_EXT  = (W_ROLHAS+1)'(LOTE_ROLHAS);
  localparam logic [W_ROLHAS:0]   MAX_EXT   = (W_ROLHAS+1)'(MAX_ROLHAS);
  localparam logic [W_ROLHAS-1:0] MAX_W     = W_ROLHAS'(MAX_ROLHAS);
  localparam logic [W_ROLHAS-1:0] LIMIAR_W  = W_ROLHAS'(LIMIAR_ALARME);
  localparam logic [3:0]          DUZIA_W   = 4'(DUZIA);
  localparam logic [W_ROLHAS:0]   UM_EXT    = (W_ROLHAS+1)'(1);
  localparam logic [W_ROLHAS:0]   ZERO_EXT  = (W_ROLHAS+1)'(0);
  localparam logic [W_ROLHAS-1:0] ZERO_W    = W_ROLHAS'(0);

  estado_t               estado_q, estado_d;
  logic [W_ROLHAS-1:0]   rolhas_q, rolhas_d;
  logic [3:0]            garrafas_q, garrafas_d;
  logic                  erro_q, erro_d;

  logic                  ev_gp_s, ev_add_s, ev_retira_s;
  logic [W_ROLHAS:0]     soma_s, liquido_s;

  detector_borda u_borda_gp (
    .clk   (clk),
    .reset (reset),
    .d     (GP),
    .borda (ev_gp_s)
  );

  detector_borda u_borda_add (
    .clk   (clk),
    .reset (reset),
    .d     (ADD),
    .borda (ev_add_s)
  );

  detector_borda u_borda_retira (
    .clk   (clk),
    .reset (reset),
    .d     (RETIRA),
    .borda (ev_retira_s)
  );

  // Stock update: reload first, then the seal consumes a cork if any is
  // available (a cork arriving with a same-cycle reload counts as available),
  // then clamp to the magazine capacity. A seal with nothing to consume flags ERRO.
  always_comb begin
    erro_d    = erro_q;
    soma_s    = {1'b0, rolhas_q};
    liquido_s = soma_s;
    if (ev_add_s) begin
      soma_s = {1'b0, rolhas_q} + LOTE_EXT;
    end else begin
      soma_s = {1'b0, rolhas_q};
    end
    if (ev_gp_s) begin
      if (soma_s != ZERO_EXT) begin
        liquido_s = soma_s - UM_EXT;
      end else begin
        liquido_s = soma_s;
        erro_d    = 1'b1;
      end
    end else begin
      liquido_s = soma_s;
    end
    if (liquido_s > MAX_EXT) begin
      rolhas_d = MAX_W;
    end else begin
      rolhas_d = liquido_s[W_ROLHAS-1:0];
    end
  end

  // Box FSM: count seals while NORMAL, hold at DUZIA in CHEIA until removal.
  always_comb begin
    estado_d   = estado_q;
    garrafas_d = garrafas_q;
    case (estado_q)
      NORMAL: begin
        if (ev_gp_s) begin
          garrafas_d = garrafas_q + 4'd1;
          if ((garrafas_q + 4'd1) == DUZIA_W) begin
            estado_d = CHEIA;
          end else begin
            estado_d = NORMAL;
          end
        end else begin
          estado_d = NORMAL;
        end
      end
      CHEIA: begin
        if (ev_retira_s) begin
          garrafas_d = 4'd0;
          estado_d   = NORMAL;
        end else begin
          estado_d   = CHEIA;
        end
      end
      default: begin
        estado_d   = NORMAL;
        garrafas_d = 4'd0;
      end
    endcase
  end

  // State and counter registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q   <= NORMAL;
      rolhas_q   <= ZERO_W;
      garrafas_q <= 4'd0;
      erro_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      rolhas_q   <= rolhas_d;
      garrafas_q <= garrafas_d;
      erro_q     <= erro_d;
    end
  end

  assign RO          = (rolhas_q != ZERO_W) && (estado_q == NORMAL);
  assign ROLHAS      = rolhas_q;
  assign GARRAFAS    = garrafas_q;
  assign CAIXA_CHEIA = (estado_q == CHEIA);
  assign ALARME      = (rolhas_q <= LIMIAR_W);
  assign ERRO        = erro_q;

endmodule

// File: tb/tb_contador_vedacao.sv
// Scoreboard bench: a reference model pushes the expected outputs at each
// rising edge, a monitor pops and compares them on the falling edge.
module tb_contador_vedacao;

  localparam int W = 7;

  logic         clk    = 1'b0;
  logic         reset  = 1'b0;
  logic         gp     = 1'b0;
  logic         add    = 1'b0;
  logic         retira = 1'b0;
  logic         ro, cheia, alarme, erro;
  logic [W-1:0] rolhas;
  logic [3:0]   garrafas;

  contador_vedacao dut (
    .clk         (clk),
    .reset       (reset),
    .GP          (gp),
    .ADD         (add),
    .RETIRA      (retira),
    .RO          (ro),
    .ROLHAS      (rolhas),
    .GARRAFAS    (garrafas),
    .CAIXA_CHEIA (cheia),
    .ALARME      (alarme),
    .ERRO        (erro)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ro;
    int rolhas;
    int garrafas;
    bit cheia;
    bit alarme;
    bit erro;
  } exp_t;

  exp_t fila[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state, as plain integers.
  int m_stock = 0;
  int m_box   = 0;
  bit m_cheia = 1'b0;
  bit m_erro  = 1'b0;
  bit p_gp = 1'b0, p_add = 1'b0, p_ret = 1'b0;
  bit e_gp, e_add, e_ret;
  int disp;
  exp_t mon_e;

  function automatic exp_t esperado();
    exp_t e;
    e.ro       = (m_stock != 0) && !m_cheia;
    e.rolhas   = m_stock;
    e.garrafas = m_box;
    e.cheia    = m_cheia;
    e.alarme   = (m_stock <= 5);
    e.erro     = m_erro;
    return e;
  endfunction

  // Reference model: rules applied with integer arithmetic each rising edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_stock = 0; m_box = 0; m_cheia = 1'b0; m_erro = 1'b0;
      p_gp = 1'b0; p_add = 1'b0; p_ret = 1'b0;
      if (clk) fila.push_back(esperado());
    end else begin
      e_gp  = gp && !p_gp;
      e_add = add && !p_add;
      e_ret = retira && !p_ret;
      p_gp = gp; p_add = add; p_ret = retira;
      disp = m_stock + (e_add ? 15 : 0);
      if (e_gp) begin
        if (disp > 0) disp = disp - 1;
        else m_erro = 1'b1;
      end
      m_stock = (disp > 100) ? 100 : disp;
      if (!m_cheia && e_gp) begin
        m_box = m_box + 1;
        if (m_box == 12) m_cheia = 1'b1;
      end else if (m_cheia && e_ret) begin
        m_box = 0;
        m_cheia = 1'b0;
      end
      fila.push_back(esperado());
    end
  end

  // Monitor: one expected vector per cycle, compared away from the active edge.
  always @(negedge clk) begin
    n_vec++;
    if (fila.size() == 0) begin
      n_err++;
      $display("FAIL saida: scoreboard empty at %0t", $time);
    end else begin
      mon_e = fila.pop_front();
      if ({ro, rolhas, garrafas, cheia, alarme, erro} !==
          {mon_e.ro, W'(mon_e.rolhas), 4'(mon_e.garrafas), mon_e.cheia, mon_e.alarme, mon_e.erro}) begin
        n_err++;
        $display("FAIL saida @%0t: got RO=%b ROLHAS=%0d GARRAFAS=%0d CHEIA=%b ALARME=%b ERRO=%b, want RO=%b ROLHAS=%0d GARRAFAS=%0d CHEIA=%b ALARME=%b ERRO=%b",
                 $time, ro, rolhas, garrafas, cheia, alarme, erro,
                 mon_e.ro, mon_e.rolhas, mon_e.garrafas, mon_e.cheia, mon_e.alarme, mon_e.erro);
      end
    end
  end

  task automatic pulso(input bit g, input bit a, input bit r, input int hi, input int lo);
    @(posedge clk); #1;
    gp = g; add = a; retira = r;
    repeat (hi) @(posedge clk);
    #1;
    gp = 1'b0; add = 1'b0; retira = 1'b0;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  // Asynchronous reset between clock edges; outputs must clear before next edge.
  task automatic reset_assincrono();
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if ({ro, rolhas, garrafas, cheia, alarme, erro} !== {1'b0, W'(0), 4'd0, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_async: got RO=%b ROLHAS=%0d GARRAFAS=%0d CHEIA=%b ALARME=%b ERRO=%b, want 0 0 0 0 1 0",
               ro, rolhas, garrafas, cheia, alarme, erro);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // Power-on reset for three cycles.
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Reload up to the clamp, ADD held several cycles each time.
    for (int i = 0; i < 7; i++) pulso(1'b0, 1'b1, 1'b0, 4, 2);

    // Fill a box, one extra seal while full, then remove the box.
    for (int i = 0; i < 13; i++) pulso(1'b1, 1'b0, 1'b0, 3, 2);
    pulso(1'b0, 1'b0, 1'b1, 2, 2);

    // Drain stock down to 2, removing boxes as they fill.
    while (m_stock > 2) begin
      if (m_cheia) pulso(1'b0, 1'b0, 1'b1, 1, 1);
      else         pulso(1'b1, 1'b0, 1'b0, 1, 1);
    end
    if (m_cheia) pulso(1'b0, 1'b0, 1'b1, 1, 1);
    // Exhaustion: last two corks, then a seal with empty magazine.
    for (int i = 0; i < 3; i++) pulso(1'b1, 1'b0, 1'b0, 2, 2);

    // Simultaneous reload and seal from empty stock.
    reset_assincrono();
    pulso(1'b1, 1'b1, 1'b0, 2, 2);

    // Build a half-full box (7 bottles, 40 corks, ERRO set) and reset mid-box.
    reset_assincrono();
    for (int i = 0; i < 2; i++) pulso(1'b1, 1'b0, 1'b0, 1, 1);
    for (int i = 0; i < 3; i++) pulso(1'b0, 1'b1, 1'b0, 1, 1);
    for (int i = 0; i < 5; i++) pulso(1'b1, 1'b0, 1'b0, 1, 1);
    reset_assincrono();

    // Randomized level stimulus.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      gp     = ($urandom_range(0, 2) == 0);
      add    = ($urandom_range(0, 12) == 0);
      retira = m_cheia ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 10) == 0);
    end
    gp = 1'b0; add = 1'b0; retira = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_vec++;
    if (fila.size() != 0) begin
      n_err++;
      $display("FAIL fila_final: %0d entries left, want 0", fila.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
